julia_frame_sequencer: RTL

Initiator side of the Julia iteration core's start/done handshake. Walks a rectangular pixel grid in raster order and derives each pixel's starting point z in fixed point. Launches one core run per pixel, waits for the core's done, and emits the iteration count as a valid/ready pixel stream toward the frame buffer writer. Sits between the host register block (frame parameters) and the core/frame-buffer path.

---
 rtl/julia_pkg.sv | 20 ++
 rtl/julia_coord_gen.sv | 88 ++++++++
 rtl/julia_frame_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia sequencer and iteration core.
package julia_pkg;

  localparam int FX_INT_BITS  = 8;
  localparam int FX_FRAC_BITS = 24;
  localparam int FX_WIDTH     = FX_INT_BITS + FX_FRAC_BITS;

  typedef logic signed [FX_WIDTH-1:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    EMIT
  } seq_state_e;

  // Escape radius squared (4.0), shared with the iteration core.
  localparam fixed_t FOUR_FX = fixed_t'(4 << FX_FRAC_BITS);

endpackage

// File: rtl/julia_coord_gen.sv
// Raster-order pixel counters with fixed-point z accumulators.
// Rows step the imaginary part downwards; no multipliers.
module julia_coord_gen
  import julia_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int XW         = $clog2(H_RES),
  parameter int YW         = $clog2(V_RES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  input  logic                         advance_i,
  input  logic signed [DATA_WIDTH-1:0] x_origin_i,
  input  logic signed [DATA_WIDTH-1:0] y_origin_i,
  input  logic signed [DATA_WIDTH-1:0] step_i,
  output logic        [XW-1:0]         px_o,
  output logic        [YW-1:0]         py_o,
  output logic signed [DATA_WIDTH-1:0] zx_o,
  output logic signed [DATA_WIDTH-1:0] zy_o,
  output logic                         last_o
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic        [XW-1:0]         px_q, px_d;
  logic        [YW-1:0]         py_q, py_d;
  logic signed [DATA_WIDTH-1:0] zx_q, zx_d;
  logic signed [DATA_WIDTH-1:0] zy_q, zy_d;
  logic signed [DATA_WIDTH-1:0] x_org_q, x_org_d;
  logic signed [DATA_WIDTH-1:0] step_q, step_d;

  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    zx_d    = zx_q;
    zy_d    = zy_q;
    x_org_d = x_org_q;
    step_d  = step_q;
    if (load_i) begin
      px_d    = '0;
      py_d    = '0;
      zx_d    = x_origin_i;
      zy_d    = y_origin_i;
      x_org_d = x_origin_i;
      step_d  = step_i;
    end else if (advance_i) begin
      if (px_q != X_LAST) begin
        px_d = px_q + XW'(1);
        zx_d = zx_q + step_q;
      end else begin
        // Row wrap: real part restarts at the latched origin.
        px_d = '0;
        zx_d = x_org_q;
        py_d = py_q + YW'(1);
        zy_d = zy_q - step_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      px_q    <= '0;
      py_q    <= '0;
      zx_q    <= '0;
      zy_q    <= '0;
      x_org_q <= '0;
      step_q  <= '0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      zx_q    <= zx_d;
      zy_q    <= zy_d;
      x_org_q <= x_org_d;
      step_q  <= step_d;
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign zx_o   = zx_q;
  assign zy_o   = zy_q;
  assign last_o = (px_q == X_LAST) && (py_q == Y_LAST);

endmodule

// File: rtl/julia_frame_sequencer.sv
// Frame walker that launches one core run per pixel and streams iteration counts.
// Optional frame cycle counter enabled by JULIA_SEQ_CYCLE_COUNT_EN.
module julia_frame_sequencer
  import julia_pkg::*;
#(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
  parameter int XW              = $clog2(H_RES),
  parameter int YW              = $clog2(V_RES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         frame_start_i,
  input  logic signed [DATA_WIDTH-1:0] x_origin_i,
  input  logic signed [DATA_WIDTH-1:0] y_origin_i,
  input  logic signed [DATA_WIDTH-1:0] step_i,
  input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
  output logic                         core_start_o,
  output logic signed [DATA_WIDTH-1:0] core_zx_o,
  output logic signed [DATA_WIDTH-1:0] core_zy_o,
  output logic [MAX_ITER_WIDTH-1:0]    core_max_iter_o,
  input  logic [MAX_ITER_WIDTH-1:0]    core_iter_i,
  input  logic                         core_done_i,
  output logic                         pix_valid_o,
  input  logic                         pix_ready_i,
  output logic [MAX_ITER_WIDTH-1:0]    pix_iter_o,
  output logic [XW-1:0]                pix_x_o,
  output logic [YW-1:0]                pix_y_o,
  output logic                         pix_last_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic [31:0]                  frame_cycles_o
);

  seq_state_e state_q, state_d;

  logic load;
  logic advance;
  logic capture;
  logic frame_end;

  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          last;

  logic [MAX_ITER_WIDTH-1:0] max_iter_q;
  logic [MAX_ITER_WIDTH-1:0] pix_iter_q;
  logic [XW-1:0]             pix_x_q;
  logic [YW-1:0]             pix_y_q;
  logic                      pix_last_q;
  logic                      frame_done_q;

  julia_coord_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .XW         (XW),
    .YW         (YW)
  ) u_coord_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .advance_i  (advance),
    .x_origin_i (x_origin_i),
    .y_origin_i (y_origin_i),
    .step_i     (step_i),
    .px_o       (px),
    .py_o       (py),
    .zx_o       (core_zx_o),
    .zy_o       (core_zy_o),
    .last_o     (last)
  );

  // core_done_i is only trusted in WAIT; the core clears it on the launch edge.
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    advance      = 1'b0;
    capture      = 1'b0;
    frame_end    = 1'b0;
    core_start_o = 1'b0;
    pix_valid_o  = 1'b0;
    busy_o       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          load    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        core_start_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (core_done_i) begin
          capture = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        pix_valid_o = 1'b1;
        if (pix_ready_i) begin
          if (pix_last_q) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            advance = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_iter_q   <= '0;
      pix_iter_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (load) begin
        max_iter_q <= max_iter_i;
      end
      if (capture) begin
        pix_iter_q <= core_iter_i;
        pix_x_q    <= px;
        pix_y_q    <= py;
        pix_last_q <= last;
      end
    end
  end

  assign core_max_iter_o = max_iter_q;
  assign pix_iter_o      = pix_iter_q;
  assign pix_x_o         = pix_x_q;
  assign pix_y_o         = pix_y_q;
  assign pix_last_o      = pix_last_q;
  assign frame_done_o    = frame_done_q;

`ifdef JULIA_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] frame_cycles_q;

  // The +1 folds in the final EMIT cycle so the total is visible with frame_done_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_q    <= '0;
      frame_cycles_q <= '0;
    end else begin
      if (load) begin
        cycle_cnt_q <= '0;
      end else if (busy_o) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (frame_end) begin
        frame_cycles_q <= cycle_cnt_q + 32'd1;
      end
    end
  end

  assign frame_cycles_o = frame_cycles_q;
`else
  assign frame_cycles_o = '0;
`endif

endmodule
